adxl362_axil_regs: RTL

AXI4-Lite responder (slave) holding the four 32-bit control/data registers of the ADXL362 controller. It is the target of the AXI4-Lite initiator traffic: the processor or master VIP performs single-beat writes and reads to byte offsets 0x0–0xC. The block exposes the register contents and per-register write strobes to the ADXL362 SPI engine. Each write and read channel handshake is AXI4-Lite compliant, with independent AW/W acceptance and registered responses.

---
 rtl/adxl362_axil_regs.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/adxl362_axil_regs.sv
`default_nettype none
// ============================================================================
// Module      : adxl362_axil_regs
// Description : AXI4-Lite responder holding the four 32-bit control/data
//               registers of the ADXL362 controller. Exposes the register
//               contents and per-register one-cycle write pulses to the
//               SPI engine.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock, reset            : rising-edge clock, asynchronous active-high reset
//   s_axi_aw* / s_axi_w*    : write address / write data channels
//   s_axi_b*                : write response channel (always OKAY)
//   s_axi_ar* / s_axi_r*    : read address / read data channels (always OKAY)
//   reg_out                 : {reg3, reg2, reg1, reg0}
//   wr_pulse                : bit i high for one cycle after a write to reg i
// ============================================================================
module adxl362_axil_regs #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    // write address channel
    input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic [2:0]                s_axi_awprot,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    // write data channel
    input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    // write response channel
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    // read address channel
    input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic [2:0]                s_axi_arprot,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    // read data channel
    output logic [DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    // register side
    output logic [4*DATA_WIDTH-1:0]   reg_out,
    output logic [3:0]                wr_pulse
);

    localparam int         c_num_regs  = 4;
    localparam int         c_num_bytes = DATA_WIDTH / 8;
    localparam logic [1:0] c_resp_okay = 2'b00;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [c_num_regs-1:0][DATA_WIDTH-1:0] r_regs;

    logic                    r_aw_held;
    logic [1:0]              r_aw_idx;
    logic                    r_w_held;
    logic [DATA_WIDTH-1:0]   r_w_data;
    logic [c_num_bytes-1:0]  r_w_strb;
    logic                    r_bvalid;
    logic [3:0]              r_wr_pulse;

    logic                    r_rvalid;
    logic [DATA_WIDTH-1:0]   r_rdata;

    // ------------------------------------------------------------------------
    // Write path: combinational handshake and commit decode
    // ------------------------------------------------------------------------
    logic                                  w_aw_hs;
    logic                                  w_w_hs;
    logic                                  w_commit;
    logic [1:0]                            w_wr_idx;
    logic [DATA_WIDTH-1:0]                 w_wr_data;
    logic [c_num_bytes-1:0]                w_wr_strb;
    logic [3:0]                            w_wr_onehot;
    logic [c_num_regs-1:0][DATA_WIDTH-1:0] w_reg_next;

    assign s_axi_awready = ~r_aw_held;
    assign s_axi_wready  = ~r_w_held;

    assign w_aw_hs = s_axi_awvalid & s_axi_awready;
    assign w_w_hs  = s_axi_wvalid  & s_axi_wready;

    // A commit needs both beats (held or arriving now) and a free B slot;
    // a slot being drained this cycle by bready counts as free.
    assign w_commit = (r_aw_held | w_aw_hs)
                    & (r_w_held  | w_w_hs)
                    & (~r_bvalid | s_axi_bready);

    // Held beats take precedence: while a flag is set the channel's ready
    // is low, so the live bus value is not meaningful for that channel.
    assign w_wr_idx  = r_aw_held ? r_aw_idx : s_axi_awaddr[3:2];
    assign w_wr_data = r_w_held  ? r_w_data : s_axi_wdata;
    assign w_wr_strb = r_w_held  ? r_w_strb : s_axi_wstrb;

    assign w_wr_onehot = 4'b0001 << w_wr_idx;

    // Byte-lane merge: each lane of each register picks new data only when
    // that register is the commit target and the lane's strobe is set.
    for (genvar gi = 0; gi < c_num_regs; gi++) begin : g_reg
        for (genvar gb = 0; gb < c_num_bytes; gb++) begin : g_byte
            assign w_reg_next[gi][gb*8 +: 8] =
                (w_commit && (w_wr_idx == 2'(gi)) && w_wr_strb[gb])
                    ? w_wr_data[gb*8 +: 8]
                    : r_regs[gi][gb*8 +: 8];
        end
    end

    // ------------------------------------------------------------------------
    // Write path: registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_regs <= '0;
        end else begin
            r_regs <= w_reg_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_aw_held <= 1'b0;
            r_aw_idx  <= 2'b00;
        end else if (w_commit) begin
            r_aw_held <= 1'b0;
        end else if (w_aw_hs) begin
            r_aw_held <= 1'b1;
            r_aw_idx  <= s_axi_awaddr[3:2];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_w_held <= 1'b0;
            r_w_data <= '0;
            r_w_strb <= '0;
        end else if (w_commit) begin
            r_w_held <= 1'b0;
        end else if (w_w_hs) begin
            r_w_held <= 1'b1;
            r_w_data <= s_axi_wdata;
            r_w_strb <= s_axi_wstrb;
        end
    end

    // A commit in the same cycle as bready keeps bvalid asserted, giving
    // back-to-back responses without a bubble.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_bvalid <= 1'b0;
        end else if (w_commit) begin
            r_bvalid <= 1'b1;
        end else if (s_axi_bready) begin
            r_bvalid <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_pulse <= 4'b0000;
        end else begin
            r_wr_pulse <= w_commit ? w_wr_onehot : 4'b0000;
        end
    end

    assign s_axi_bvalid = r_bvalid;
    assign s_axi_bresp  = c_resp_okay;
    assign wr_pulse     = r_wr_pulse;
    assign reg_out      = r_regs;

    // ------------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------------
    logic w_ar_hs;

    assign s_axi_arready = ~r_rvalid;
    assign w_ar_hs       = s_axi_arvalid & s_axi_arready;

    // rdata samples the pre-edge register contents, so a read colliding
    // with a commit on the same edge returns the old value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= r_regs[s_axi_araddr[3:2]];
        end else if (s_axi_rready) begin
            r_rvalid <= 1'b0;
        end
    end

    assign s_axi_rvalid = r_rvalid;
    assign s_axi_rdata  = r_rdata;
    assign s_axi_rresp  = c_resp_okay;

    // Protection bits and the byte offset within a word carry no meaning
    // for this register file.
    logic w_unused;
    assign w_unused = &{1'b0, s_axi_awprot, s_axi_arprot, s_axi_awaddr, s_axi_araddr};

endmodule
`default_nettype wire
